// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: pc_control encodings, fetch FSM states, opcode constants and
// sign-extension helpers for branch immediates.
package kgp_pkg;

    localparam logic [3:0] PC_SEQ    = 4'b0000;
    localparam logic [3:0] PC_B      = 4'b0001;
    localparam logic [3:0] PC_BR     = 4'b0010;
    localparam logic [3:0] PC_CND_LO = 4'b0011;
    localparam logic [3:0] PC_CND_HI = 4'b1010;
    localparam logic [3:0] PC_CALL   = 4'b1011;
    localparam logic [3:0] PC_RET    = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE
    } fetch_state_e;

    localparam logic [5:0] OPC_ALU    = 6'h00;
    localparam logic [5:0] OPC_ALUI   = 6'h01;
    localparam logic [5:0] OPC_LDST   = 6'h02;
    localparam logic [5:0] OPC_BRANCH = 6'h03;
    localparam logic [5:0] OPC_CALL   = 6'h04;
    localparam logic [5:0] OPC_RET    = 6'h05;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sext26(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

endpackage

// File: rtl/kgp_ras.sv
// Circular return-address stack: push on full overwrites the oldest entry, pop on empty is a no-op.
module kgp_ras
    import kgp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] data_i,
    output logic [31:0] top_o,
    output logic        empty_o,
    output logic        full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] top_ptr;
    logic [CW-1:0] cnt_q;

    assign top_ptr = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - 1'b1;
    assign top_o   = mem_q[top_ptr];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // The count saturates at DEPTH so a wrapped stack still reports full rather than empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (push_i) begin
            wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (!full_o) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            wr_ptr_q <= top_ptr;
            cnt_q    <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/kgp_fetch_unit.sv
// KGP-RISC instruction fetch front-end: PC register, fetch/issue FSM, next-PC selection and
// CALL/RET linkage. Define KGP_FETCH_RAS_EN for a RAS_DEPTH-entry return stack instead of one link register.
module kgp_fetch_unit
    import kgp_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic        instr_ready,
    input  logic [3:0]  pc_control,
    input  logic [31:0] br_target,
    output logic [31:0] link_addr,
    output logic        illegal_pc,
    output logic        ras_err
);
    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d, instruction_q, seq, ret_target;
    logic         imem_req_q, instr_valid_q, illegal_q, illegal_d;
    logic         retire, do_call, do_ret;

    assign seq     = pc_q + 32'd4;
    assign retire  = (state_q == ST_ISSUE) && instr_ready;
    assign do_call = retire && (pc_control == PC_CALL);
    assign do_ret  = retire && (pc_control == PC_RET);

`ifdef KGP_FETCH_RAS_EN
    logic [31:0] ras_top;
    logic        ras_empty, ras_err_q, unused_ras_full;

    kgp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (do_call),
        .pop_i   (do_ret),
        .data_i  (seq),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (unused_ras_full)
    );

    assign ret_target = ras_empty ? RESET_PC : ras_top;

    always_ff @(posedge clk) begin
        if (rst) ras_err_q <= 1'b0;
        else     ras_err_q <= do_ret && ras_empty;
    end
    assign ras_err = ras_err_q;
`else
    logic [31:0] link_q;
    logic        unused_cfg;

    assign unused_cfg = ^RAS_DEPTH;
    assign ret_target = link_q;
    assign ras_err    = 1'b0;

    always_ff @(posedge clk) begin
        if (rst)          link_q <= '0;
        else if (do_call) link_q <= seq;
    end
`endif

    always_comb begin
        pc_d      = seq;
        illegal_d = 1'b0;
        case (pc_control)
            PC_SEQ:        pc_d = seq;
            PC_B, PC_CALL: pc_d = seq + (sext26(instruction_q[25:0]) << 2);
            PC_BR:         pc_d = br_target & 32'hFFFF_FFFC;
            PC_RET:        pc_d = ret_target;
            default: begin
                if (pc_control > PC_RET) illegal_d = 1'b1;
                else                     pc_d = seq + (sext16(instruction_q[15:0]) << 2);
            end
        endcase
    end

    // IDLE exists only so imem_req stays low through reset and rises the cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                end
                ST_FETCH: if (imem_ack) begin
                    instruction_q <= imem_rdata;
                    instr_valid_q <= 1'b1;
                    imem_req_q    <= 1'b0;
                    state_q       <= ST_ISSUE;
                end
                ST_ISSUE: if (instr_ready) begin
                    pc_q          <= pc_d;
                    illegal_q     <= illegal_d;
                    instr_valid_q <= 1'b0;
                    imem_req_q    <= 1'b1;
                    state_q       <= ST_FETCH;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign instruction = instruction_q;
    assign link_addr   = seq;
    assign illegal_pc  = illegal_q;

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Directed bench for kgp_fetch_unit: sequential fetch, branches, CALL/RET, reserved codes, PC wrap and reset.
module tb_kgp_fetch_unit;
    import kgp_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, instr_valid, instr_ready, illegal_pc, ras_err;
    logic [31:0] imem_addr, imem_rdata, instruction, pc, br_target, link_addr;
    logic [3:0]  pc_control;
    logic [31:0] exp_ret [5];
    logic [31:0] cur;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    kgp_fetch_unit #(.RESET_PC(RST_PC), .RAS_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .pc          (pc),
        .instr_ready (instr_ready),
        .pc_control  (pc_control),
        .br_target   (br_target),
        .link_addr   (link_addr),
        .illegal_pc  (illegal_pc),
        .ras_err     (ras_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait for a request, check its address, answer after lat cycles and check the issued word.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] word,
                            input int lat);
        int n = 0;
        @(negedge clk);
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req"}, 32'(imem_req), 32'd1);
        check_eq({tag, "_addr"}, imem_addr, addr);
        repeat (lat) @(negedge clk);
        if (lat > 0) check_eq({tag, "_hold"}, 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check_eq({tag, "_instr"}, instruction, word);
        check_eq({tag, "_pc"}, pc, addr);
    endtask

    task automatic retire(input logic [3:0] ctl, input logic [31:0] bt);
        instr_ready = 1'b1;
        pc_control  = ctl;
        br_target   = bt;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_control  = PC_SEQ;
        br_target   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; pc_control = PC_SEQ; br_target = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_pc", pc, RST_PC);
        check_eq("rst_instr", instruction, 32'd0);
        check_eq("rst_illegal", 32'(illegal_pc), 32'd0);
        check_eq("rst_ras_err", 32'(ras_err), 32'd0);
        rst = 1'b0;

        // Sequential fetch from RESET_PC with a 2-cycle memory
        do_fetch("t1a", 32'h100, 32'h0, 2);
        retire(PC_SEQ, '0);
        do_fetch("t1b", 32'h104, 32'h0, 2);
        retire(PC_SEQ, '0);
        do_fetch("t1c", 32'h108, 32'h0, 2);
        retire(PC_SEQ, '0);
        do_fetch("t1d", 32'h10C, 32'h0, 2);
        check_eq("t1_link", link_addr, 32'h110);

        // Conditional branches with negative and positive imm16
        retire(PC_BR, 32'h200);
        do_fetch("t2a", 32'h200, 32'h0000_FFFE, 1);
        retire(4'b0011, '0);
        do_fetch("t2b", 32'h1FC, 32'h0, 0);
        retire(PC_BR, 32'h200);
        do_fetch("t2c", 32'h200, 32'h0000_0001, 1);
        retire(4'b1010, '0);
        do_fetch("t2d", 32'h208, 32'h0, 1);

        // CALL then RET
        retire(PC_BR, 32'h40);
        do_fetch("t3a", 32'h40, 32'h0000_0004, 1);
        check_eq("t3_link", link_addr, 32'h44);
        retire(PC_CALL, '0);
        do_fetch("t3b", 32'h54, 32'h0, 1);
        retire(PC_RET, '0);
        check_eq("t3_ras_err", 32'(ras_err), 32'd0);
        do_fetch("t3c", 32'h44, 32'h0, 1);

        // Reserved pc_control, then BR with low bits set
        retire(4'b1110, '0);
        check_eq("t5_ill_hi", 32'(illegal_pc), 32'd1);
        @(negedge clk);
        check_eq("t5_ill_lo", 32'(illegal_pc), 32'd0);
        do_fetch("t5a", 32'h48, 32'h0, 0);
        retire(PC_BR, 32'h303);
        check_eq("t5_ill_br", 32'(illegal_pc), 32'd0);
        do_fetch("t5b", 32'h300, 32'h0, 1);

        // PC wrap and a negative imm26 B that wraps back
        retire(PC_BR, 32'hFFFF_FFFC);
        do_fetch("wrap_a", 32'hFFFF_FFFC, 32'h0, 0);
        retire(PC_SEQ, '0);
        do_fetch("wrap_b", 32'h0, 32'h03FF_FFFE, 0);
        retire(PC_B, '0);
        do_fetch("b_neg", 32'hFFFF_FFFC, 32'h0, 0);

`ifdef KGP_FETCH_RAS_EN
        // Five nested CALLs on a 4-deep stack, then five RETs
        retire(PC_BR, 32'h1000);
        cur = 32'h1000;
        do_fetch("t4_c0", cur, 32'h4, 0);
        for (int i = 0; i < 5; i++) begin
            exp_ret[i] = cur + 32'd4;
            retire(PC_CALL, '0);
            cur = cur + 32'd20;
            do_fetch($sformatf("t4_call%0d", i), cur, 32'h4, 0);
        end
        for (int j = 0; j < 4; j++) begin
            retire(PC_RET, '0);
            check_eq($sformatf("t4_rerr%0d", j), 32'(ras_err), 32'd0);
            do_fetch($sformatf("t4_ret%0d", j), exp_ret[4-j], 32'h0, 0);
        end
        retire(PC_RET, '0);
        check_eq("t4_underflow_err", 32'(ras_err), 32'd1);
        @(negedge clk);
        check_eq("t4_err_pulse", 32'(ras_err), 32'd0);
        do_fetch("t4_under", RST_PC, 32'h0, 0);
`else
        // Single link register: the second CALL overwrites the first
        retire(PC_BR, 32'h1000);
        do_fetch("lk_a", 32'h1000, 32'h4, 0);
        retire(PC_CALL, '0);
        do_fetch("lk_b", 32'h1014, 32'h4, 0);
        retire(PC_CALL, '0);
        do_fetch("lk_c", 32'h1028, 32'h0, 0);
        retire(PC_RET, '0);
        check_eq("lk_rerr", 32'(ras_err), 32'd0);
        do_fetch("lk_r1", 32'h1018, 32'h0, 0);
        retire(PC_RET, '0);
        do_fetch("lk_r2", 32'h1018, 32'h0, 0);
`endif

        // Reset during a pending fetch with a coinciding ack, plus a late ack
        retire(PC_SEQ, '0);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("t6_req", 32'(imem_req), 32'd0);
        check_eq("t6_valid", 32'(instr_valid), 32'd0);
        check_eq("t6_pc", pc, RST_PC);
        rst = 1'b0;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check_eq("t6_late_ack", 32'(instr_valid), 32'd0);
        do_fetch("t6", RST_PC, 32'h0000_0011, 0);

        // Reset while an instruction is being issued
        rst = 1'b1;
        @(negedge clk);
        check_eq("t7_valid", 32'(instr_valid), 32'd0);
        check_eq("t7_instr", instruction, 32'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
